// File: rtl/regfile_wr_arbiter_if.sv
// Writeback-source / register-file write-port bundle for regfile_wr_arbiter.
// master = sources, issue logic and register file; slave = the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  localparam int NREG = 1 << AW;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               claim_valid;
  logic [AW-1:0]      claim_addr;
  logic               RegWr;
  logic [AW-1:0]      WriteReg;
  logic [DW-1:0]      WriteData;
  logic [NREG-1:0]    pend_mask;
  logic               err_unclaimed;

  modport master (
    output req_valid, req_addr, req_data, claim_valid, claim_addr,
    input  req_ready, RegWr, WriteReg, WriteData, pend_mask, err_unclaimed
  );
  modport slave (
    input  req_valid, req_addr, req_data, claim_valid, claim_addr,
    output req_ready, RegWr, WriteReg, WriteData, pend_mask, err_unclaimed
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// ARB_RR_EN selects round-robin; otherwise fixed priority req0 > req1 > req2.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input logic                clk,
  input logic                rst,
  regfile_wr_arbiter_if.slave bus
);
  localparam int IW   = $clog2(NREQ);
  localparam int NREG = 1 << AW;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gIdx;
  logic [IW-1:0]   idx;
  logic            anyGnt;
  logic [AW-1:0]   gAddr;
  logic [NREG-1:0] pendNxt;
  logic            errSet;

`ifdef ARB_RR_EN
  logic [IW-1:0] lastGnt;
`endif

  // Grant depends only on req_valid and the pointer, never on addr/data.
  always_comb begin
    gnt    = '0;
    gIdx   = '0;
    idx    = '0;
    anyGnt = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_RR_EN
      idx = IW'((int'(lastGnt) + 1 + k) % NREQ);
`else
      idx = IW'(k);
`endif
      if (!anyGnt && bus.req_valid[idx]) begin
        anyGnt   = 1'b1;
        gnt[idx] = 1'b1;
        gIdx     = idx;
      end
    end
  end

  assign bus.req_ready = gnt;
  assign gAddr         = bus.req_addr[gIdx*AW +: AW];

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        lastGnt <= IW'(NREQ - 1);
    else if (anyGnt) lastGnt <= gIdx;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.RegWr     <= 1'b0;
      bus.WriteReg  <= '0;
      bus.WriteData <= '0;
    end else begin
      // r0 writes complete the handshake but never raise RegWr.
      bus.RegWr <= anyGnt && (gAddr != '0);
      if (anyGnt) begin
        bus.WriteReg  <= gAddr;
        bus.WriteData <= bus.req_data[gIdx*DW +: DW];
      end
    end
  end

  // Retirement clears first so a same-cycle claim of that register wins.
  always_comb begin
    pendNxt = bus.pend_mask;
    if (bus.RegWr) pendNxt[bus.WriteReg] = 1'b0;
    if (bus.claim_valid && bus.claim_addr != '0) pendNxt[bus.claim_addr] = 1'b1;
    pendNxt[0] = 1'b0;
  end

  assign errSet = bus.RegWr && (bus.WriteReg != '0) && !bus.pend_mask[bus.WriteReg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.pend_mask     <= '0;
      bus.err_unclaimed <= 1'b0;
    end else begin
      bus.pend_mask <= pendNxt;
      if (errSet) bus.err_unclaimed <= 1'b1;
    end
  end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single register-file write port of the multi-cycle CPU among three writeback sources: ALU result, load data, and debug/host write. It also keeps a pending-write scoreboard so decode can stall on operands still in flight. It sits between the writeback sources and the register file. Its registered outputs drive RegWr/WriteReg/WriteData directly; the register file commits on the following negedge.

## Interface
- NREQ, 3, number of requesters (fixed; ports below are per index 0..2)
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  clock, posedge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  3  requester i has a write pending
- req_addr  in  3*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  in  3*DW  write data, requester i at bits [i*DW +: DW]
- req_ready  out  3  combinational grant; a transfer occurs on a posedge where valid&ready
- claim_valid  in  1  issue logic reserves a destination register
- claim_addr  in  AW  register being reserved
- RegWr  out  1  register-file write enable (registered)
- WriteReg  out  AW  register-file write address (registered)
- WriteData  out  DW  register-file write data (registered)
- pend_mask  out  32  bit r set = write to r outstanding
- err_unclaimed  out  1  sticky; a write retired to a nonzero register whose pend bit was clear

## Operation
- Arbitration:
  - Each cycle, at most one req_ready is high, and only for a valid requester.
  - With no valid requester, req_ready = 0.
  - Requesters hold valid/addr/data stable until accepted.
  - Dropping valid without a handshake is illegal and is not checked.
- Acceptance: on a posedge with a handshake on requester g, load RegWr=1, WriteReg=req_addr[g], WriteData=req_data[g].
  - If req_addr[g]==0, the transfer is accepted (ready asserted) but RegWr stays 0. r0 is never written.
- With no handshake, RegWr=0 at the next posedge. WriteReg and WriteData hold their previous values.
- Throughput: one write per cycle. The output register never back-pressures.
- Scoreboard:
  - claim_valid with claim_addr≠0 sets pend_mask[claim_addr] at the posedge.
  - The posedge that ends a cycle with RegWr=1 clears pend_mask[WriteReg].
  - Simultaneous set and clear of the same bit: set wins (a new claim is outstanding).
  - pend_mask[0] is always 0.
- err_unclaimed sets when RegWr=1, WriteReg≠0, and pend_mask[WriteReg]=0 during that cycle. Cleared only by reset.
- Reset (asynchronous, any cycle, mid-transfer included) forces:
  - RegWr=0, WriteReg=0, WriteData=0.
  - pend_mask=0, err_unclaimed=0.
  - Round-robin pointer = 2, so requester 0 is first.
  - An in-flight write is discarded.

## Timing
- Handshake at posedge k:
  - RegWr/WriteReg/WriteData valid during cycle k..k+1.
  - Register file commits at the negedge inside that cycle.
  - The value is readable from the register file in the second half of that cycle.
- pend bit clears at posedge k+1. Decode sampling pend_mask after k+1 sees the register free.
- req_ready is a combinational function of req_valid and the registered pointer only. There is no path from req_addr or req_data.
- claim to pend_mask: 1 cycle.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - The search starts at (last_grant+1) mod 3.
  - The pointer updates to g only on a handshake.
  - Worst-case wait for a continuously valid requester is 2 cycles.
- ARB_RR_EN undefined: fixed priority req0 > req1 > req2.
  - The pointer register is not implemented.
  - Starvation of lower indices is permitted.

## Test plan
- Reset release, all requesters valid, ARB_RR_EN defined:
  - Grants run 0,1,2,0 on consecutive cycles.
  - RegWr=1 for 4 cycles with WriteReg following each grant's address.
  - Same stimulus with ARB_RR_EN undefined: only req0 is granted.
- Claim r5 at cycle 0, then req1 writes r5=0xDEADBEEF at cycle 3:
  - pend_mask[5]=1 from cycle 1 until the posedge after RegWr.
  - The register file holds 0xDEADBEEF.
  - err_unclaimed stays 0.
- Claim r7 in the same cycle that RegWr=1 with WriteReg=7: pend_mask[7] remains 1.
- req0 writes r0=0x12345678: req_ready[0]=1, RegWr stays 0, pend_mask and err_unclaimed are unchanged.
- req2 writes r9=0x1 with no prior claim: err_unclaimed=1 one cycle after RegWr and stays high until reset.
- Assert rst low while RegWr=1 and pend_mask=0x0000_00A0:
  - Immediately RegWr=0, pend_mask=0, err_unclaimed=0.
  - After release, the first grant goes to req0 (ARB_RR_EN defined).
